// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential restoring divider:
//   DEFAULT_N : default operand/result width
//   state_t   : divider FSM state encoding
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN adds the FIX state used to
// apply signs to the unsigned magnitude result.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

   localparam int DEFAULT_N = 8;

`ifdef SEQ_DIVIDER_SIGNED_EN
   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FIX
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE,
      BUSY
   } state_t;
`endif

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Request/result bundle of the sequential divider.
//   start     : begin a division (sampled while ready=1)
//   dividend  : numerator, captured on the accepting edge
//   divisor   : denominator, captured on the accepting edge
//   quotient  : result quotient, held until the next accepted start
//   remainder : result remainder, held until the next accepted start
//   ready     : idle, results valid, new start accepted
//   error     : divide-by-zero flag of the last completed operation
// Modports: master drives requests, slave (the divider) drives results.
// -----------------------------------------------------------------------------
interface seq_divider_if
   import seq_divider_pkg::*;
#(
   parameter int N = DEFAULT_N
);

   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         ready;
   logic         error;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, ready, error
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, ready, error
   );

endinterface

// File: rtl/seq_div_sub.sv
// -----------------------------------------------------------------------------
// seq_div_sub
// Combinational W-bit subtractor used for the trial subtraction of each
// restoring iteration.
//   a, b   : minuend and subtrahend
//   diff   : a - b modulo 2^W
//   borrow : 1 when b > a
// -----------------------------------------------------------------------------
module seq_div_sub #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider, one quotient bit per clock.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : seq_divider_if.slave (start/dividend/divisor in,
//           quotient/remainder/ready/error out)
// Latency from the accepting edge to ready=1 is N edges, or 1 edge for a
// zero divisor. Optional macro SEQ_DIVIDER_SIGNED_EN makes the operands
// two's complement: magnitudes are divided and an extra FIX edge applies
// the signs (truncation toward zero), giving latency N+1.
// -----------------------------------------------------------------------------
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clock,
   input  logic         reset,
   seq_divider_if.slave bus
);

   localparam int CW = $clog2(N + 1);

   state_t        state;
   logic [CW-1:0] cnt;

   logic [N:0]    acc;       // partial remainder
   logic [N-1:0]  qr;        // dividend bits shifting out, quotient bits in
   logic [N-1:0]  dvs;       // divisor (magnitude in signed mode)
   logic          dz;        // captured divide-by-zero

   logic [N:0]    shifted;
   logic [N:0]    diff;
   logic          borrow;
   logic          take;
   logic [N:0]    acc_nxt;
   logic [N-1:0]  qr_nxt;

   logic [N-1:0]  dd_load;
   logic [N-1:0]  dvs_load;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic                neg_q;
   logic                neg_r;
   logic signed [N-1:0] dd_s;
   logic signed [N-1:0] dv_s;
   logic signed [N-1:0] q_s;
   logic signed [N-1:0] r_s;

   assign dd_s = $signed(bus.dividend);
   assign dv_s = $signed(bus.divisor);
   assign q_s  = $signed(qr);
   assign r_s  = $signed(acc[N-1:0]);

   // A zero divisor keeps the raw dividend so it can be returned as remainder.
   // The most-negative value maps onto itself, which is its correct unsigned
   // magnitude.
   assign dd_load  = (dd_s < 0 && bus.divisor != '0) ? $unsigned(-dd_s) : bus.dividend;
   assign dvs_load = (dv_s < 0) ? $unsigned(-dv_s) : bus.divisor;
`else
   assign dd_load  = bus.dividend;
   assign dvs_load = bus.divisor;
`endif

   assign shifted = {acc[N-1:0], qr[N-1]};

   seq_div_sub #(.W(N + 1)) u_sub (
      .a      (shifted),
      .b      ({1'b0, dvs}),
      .diff   (diff),
      .borrow (borrow)
   );

   // A bit shifted out of acc would make the shifted value exceed any
   // divisor, so the subtraction is taken regardless of the borrow; the
   // restoring invariant keeps that bit at zero.
   assign take    = ~borrow | acc[N];
   assign acc_nxt = take ? diff : shifted;
   assign qr_nxt  = {qr[N-2:0], take};

   // Datapath registers: loaded on acceptance, iterated while BUSY.
   always_ff @(posedge clock) begin
      if (state == IDLE && bus.start) begin
         acc   <= '0;
         qr    <= dd_load;
         dvs   <= dvs_load;
         dz    <= (bus.divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
         neg_r <= bus.dividend[N-1];
`endif
      end else if (state == BUSY) begin
         acc <= acc_nxt;
         qr  <= qr_nxt;
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
         bus.ready     <= 1'b1;
         bus.error     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= BUSY;
                  cnt       <= CW'(N);
                  bus.error <= 1'b0;
                  bus.ready <= 1'b0;
               end
            end
            BUSY: begin
               if (dz) begin
                  // qr still holds the raw dividend on this edge
                  bus.quotient  <= '1;
                  bus.remainder <= qr;
                  bus.error     <= 1'b1;
                  bus.ready     <= 1'b1;
                  cnt           <= '0;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                     state <= FIX;
`else
                     bus.quotient  <= qr_nxt;
                     bus.remainder <= acc_nxt[N-1:0];
                     bus.ready     <= 1'b1;
                     state         <= IDLE;
`endif
                  end
               end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            FIX: begin
               bus.quotient  <= neg_q ? $unsigned(-q_s) : qr;
               bus.remainder <= neg_r ? $unsigned(-r_s) : acc[N-1:0];
               bus.ready     <= 1'b1;
               state         <= IDLE;
            end
`endif
            default: begin
               state     <= IDLE;
               bus.ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   localparam int N = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam int LAT = N + 1;
`else
   localparam int LAT = N;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seq_divider_if #(.N(N)) bus ();

   seq_divider #(.N(N)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference: plain arithmetic on the operand values.
   function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] q, output logic [N-1:0] r,
                                 output logic e);
      int sa;
      int sb;
      if (b == '0) begin
         q = '1;
         r = a;
         e = 1'b1;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         sa = $signed(a);
         sb = $signed(b);
`else
         sa = int'(a);
         sb = int'(b);
`endif
         q = N'(sa / sb);
         r = N'(sa % sb);
         e = 1'b0;
      end
   endfunction

   // Issue one division (ready must be 1), optionally pulsing a stray start
   // after pulse_at busy edges, then check latency and results.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int pulse_at, input string tag);
      logic [N-1:0] eq;
      logic [N-1:0] er;
      logic         ee;
      int           lat;
      int           exp_lat;
      model(a, b, eq, er, ee);
      exp_lat = (b == '0) ? 1 : LAT;
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      do begin
         if (pulse_at != 0 && lat == pulse_at) begin
            bus.start    = 1'b1;
            bus.dividend = 8'd9;
            bus.divisor  = 8'd3;
         end
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         lat++;
      end while (!bus.ready && lat < 40);
      checks++;
      if (lat != exp_lat) begin
         failures++;
         $display("FAIL %s latency %0d/%0d: got %0d want %0d", tag, a, b, lat, exp_lat);
      end
      checks++;
      if (bus.quotient !== eq) begin
         failures++;
         $display("FAIL %s quotient %0d/%0d: got %h want %h", tag, a, b, bus.quotient, eq);
      end
      checks++;
      if (bus.remainder !== er) begin
         failures++;
         $display("FAIL %s remainder %0d/%0d: got %h want %h", tag, a, b, bus.remainder, er);
      end
      checks++;
      if (bus.error !== ee) begin
         failures++;
         $display("FAIL %s error %0d/%0d: got %b want %b", tag, a, b, bus.error, ee);
      end
   endtask

   task automatic check_reset_state(input string tag);
      checks++;
      if (bus.ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready: got %b want 1", tag, bus.ready);
      end
      checks++;
      if (bus.quotient !== '0) begin
         failures++;
         $display("FAIL %s quotient: got %h want 00", tag, bus.quotient);
      end
      checks++;
      if (bus.remainder !== '0) begin
         failures++;
         $display("FAIL %s remainder: got %h want 00", tag, bus.remainder);
      end
      checks++;
      if (bus.error !== 1'b0) begin
         failures++;
         $display("FAIL %s error: got %b want 0", tag, bus.error);
      end
   endtask

   task automatic test_reset();
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst = 1'b1;
      #12;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      run_op(8'd100, 8'd7, 0, "div_100_7");
      run_op(8'd255, 8'd16, 0, "div_255_16");
      run_op(8'd3, 8'd200, 0, "div_small");
   endtask

   task automatic test_div_zero();
      run_op(8'd55, 8'd0, 0, "div_zero");
      run_op(8'd20, 8'd5, 0, "after_zero");
   endtask

   task automatic test_ignore_start();
      run_op(8'd100, 8'd7, 2, "ignore_start");
   endtask

   task automatic test_reset_mid();
      bus.start    = 1'b1;
      bus.dividend = 8'd100;
      bus.divisor  = 8'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_state("reset_mid");
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_op(8'd255, 8'd1, 0, "after_reset");
   endtask

   task automatic test_random();
      logic [N-1:0] a;
      logic [N-1:0] b;
      for (int i = 0; i < 40; i++) begin
         a = N'($urandom_range(0, 255));
         b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 255));
         run_op(a, b, 0, "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] eq;
      logic [N-1:0] er;
      logic         ee;
      int           lat;
      int           w;
      bus.start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a = N'($urandom_range(0, 255));
         b = N'($urandom_range(1, 255));
         model(a, b, eq, er, ee);
         bus.dividend = a;
         bus.divisor  = b;
         @(posedge clk);
         #1;
         checks++;
         if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b accept: got ready %b want 0", bus.ready);
         end
         lat = 0;
         do begin
            @(posedge clk);
            #1;
            lat++;
         end while (!bus.ready && lat < 40);
         checks++;
         if (lat != LAT) begin
            failures++;
            $display("FAIL b2b latency: got %0d want %0d", lat, LAT);
         end
         checks++;
         if (bus.quotient !== eq || bus.remainder !== er) begin
            failures++;
            $display("FAIL b2b result %0d/%0d: got %h r %h want %h r %h",
                     a, b, bus.quotient, bus.remainder, eq, er);
         end
      end
      bus.start = 1'b0;
      w = 0;
      while (!bus.ready && w < 40) begin
         @(posedge clk);
         #1;
         w++;
      end
      checks++;
      if (bus.ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b drain: got ready %b want 1", bus.ready);
      end
   endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
   task automatic test_signed();
      run_op(8'h9C, 8'd7, 0, "signed_m100_7");
      checks++;
      if (bus.quotient !== 8'hF2 || bus.remainder !== 8'hFE) begin
         failures++;
         $display("FAIL signed_m100_7 const: got %h r %h want f2 r fe",
                  bus.quotient, bus.remainder);
      end
      run_op(8'h80, 8'hFF, 0, "signed_min_m1");
      run_op(8'd100, 8'hF9, 0, "signed_100_m7");
      run_op(8'hF0, 8'hFD, 0, "signed_m16_m3");
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_random();
      test_back_to_back();
`ifdef SEQ_DIVIDER_SIGNED_EN
      test_signed();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one parameter: N, default 8, operand and result width in bits (N >= 2).
REQ-002 Port clock  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  SHALL be asynchronous and active-high.
REQ-004 Port start  input  1  SHALL be a request to begin a division, sampled only while ready=1.
REQ-005 Port dividend  input  N  SHALL be the numerator, captured on the accepting edge.
REQ-006 Port divisor  input  N  SHALL be the denominator, captured on the accepting edge.
REQ-007 Port quotient  output  N  SHALL be the result quotient, held until the next accepted start.
REQ-008 Port remainder  output  N  SHALL be the result remainder, held until the next accepted start.
REQ-009 Port ready  output  1  SHALL be high when idle, with results valid and a new start accepted.
REQ-010 Port error  output  1  SHALL flag divide-by-zero for the last completed operation.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY and FIX; FIX exists only when the signed feature is compiled in.
REQ-012 IDLE with start=1: capture operands, clear error, load iteration counter with N, go to BUSY, ready=0 from that edge.
REQ-013 IDLE with start=0: hold all outputs.
REQ-014 BUSY: one restoring iteration per edge -- shift {A,Q} left, A-M via subtractor, restore on borrow, set Q LSB to NOT borrow, decrement counter.
REQ-015 After the Nth BUSY edge the FSM SHALL go to IDLE (unsigned) or FIX (signed); ready=1 exactly N edges (unsigned) or N+1 edges (signed) after the accepting edge.
REQ-016 The partial remainder register SHALL be N+1 bits wide so that no iteration overflows; quotient and remainder SHALL be the low N bits.
REQ-017 start asserted while ready=0 SHALL be ignored, with no effect on the result in progress.
REQ-018 divisor=0 SHALL skip BUSY: the next edge returns to IDLE with error=1, quotient all ones, remainder=dividend.
REQ-019 start held high continuously SHALL start a new operation on every edge where ready=1.

Reset
REQ-020 Asserting reset, including mid-operation, SHALL immediately force IDLE with ready=1, quotient=0, remainder=0, error=0 and counter=0.
REQ-021 The first start after reset release SHALL be accepted normally.

Configuration
REQ-022 With macro SEQ_DIVIDER_SIGNED_EN defined, operands SHALL be two's complement.
- Magnitudes are divided unsigned.
- FIX negates the quotient if the operand signs differ, and gives the remainder the sign of the dividend (truncation toward zero).
REQ-023 Signed mode: most-negative / -1 SHALL return quotient=most-negative, remainder=0, error=0.
REQ-024 Without the macro, operands SHALL be unsigned, the FIX state and its logic SHALL not exist, and latency SHALL be N.

Structure
REQ-025 Package seq_divider_pkg SHALL hold the FSM state enum and the default width constant.
REQ-026 Sub-module seq_div_sub SHALL be a combinational (N+1)-bit subtractor with difference and borrow outputs, instantiated once.

Verification (N=8)
REQ-027 Unsigned 100/7 -> quotient=14, remainder=2, error=0; ready low 8 cycles, high on the 8th edge after the accepting edge.
REQ-028 55/0 -> one cycle later: ready=1, error=1, quotient=8'hFF, remainder=55.
REQ-029 Start 100/7, then pulse start with 9/3 on the 3rd busy cycle -> result still 14 remainder 2; 9/3 is not executed.
REQ-030 Reset asserted on the 4th busy cycle -> ready=1, quotient=0, remainder=0 immediately; a following 255/1 -> 255 remainder 0.
REQ-031 With SEQ_DIVIDER_SIGNED_EN:
- -100/7 -> quotient=8'hF2, remainder=8'hFE after 9 cycles.
- -128/-1 -> quotient=8'h80, remainder=0, error=0.
